// File: rtl/obi_manager_be.sv
// Single-outstanding OBI manager: turns byte/half/word controller commands into
// lane-aligned OBI A-channel requests and returns zero-extended R-channel responses.
module obi_manager_be #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [1:0]            cmd_size_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [3:0]            obi_be_o,
    output logic [DATA_WIDTH-1:0] obi_wdata_o,
    input  logic                  obi_rvalid_i,
    output logic                  obi_rready_o,
    input  logic [DATA_WIDTH-1:0] obi_rdata_i,
    input  logic                  obi_err_i
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RSP  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    we_r;
    logic [1:0]              size_r;
    logic [3:0]              be_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    err_r;
    logic                    misaligned_s;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] base;
        case (size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            2'd2:    base = 4'b1111;
            default: base = 4'b0000;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = off[0];
            2'd2:    mis = (off != 2'd0);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract_rdata(input logic [DATA_WIDTH-1:0] raw,
                                                            input logic [1:0] size,
                                                            input logic [1:0] off);
        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] res;
        shifted = raw >> {off, 3'b000};
        case (size)
            2'd0:    res = {24'h000000, shifted[7:0]};
            2'd1:    res = {16'h0000, shifted[15:0]};
            default: res = shifted;
        endcase
        return res;
    endfunction

    assign misaligned_s = is_misaligned(cmd_size_i, cmd_addr_i[1:0]);

    // Handshake outputs are pure decodes of the state register.
    assign cmd_ready_o  = (state_r == IDLE);
    assign obi_req_o    = (state_r == REQ);
    assign obi_rready_o = (state_r == RSP);
    assign rsp_valid_o  = (state_r == DONE);
    assign obi_addr_o   = addr_r;
    assign obi_we_o     = we_r;
    assign obi_be_o     = be_r;
    assign obi_wdata_o  = wdata_r;
    assign rsp_rdata_o  = rdata_r;
    assign rsp_err_o    = err_r;

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; misaligned commands skip the bus and report at once.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_next_s = misaligned_s ? DONE : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (obi_gnt_i) begin
                    state_next_s = RSP;
                end else begin
                    state_next_s = REQ;
                end
            end
            RSP: begin
                if (obi_rvalid_i) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RSP;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Command capture with lane alignment, and response capture.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            addr_r  <= {ADDR_WIDTH{1'b0}};
            we_r    <= 1'b0;
            size_r  <= 2'd0;
            be_r    <= 4'b0000;
            wdata_r <= {DATA_WIDTH{1'b0}};
            rdata_r <= {DATA_WIDTH{1'b0}};
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_r  <= cmd_addr_i;
                        we_r    <= cmd_we_i;
                        size_r  <= cmd_size_i;
                        be_r    <= lane_be(cmd_size_i, cmd_addr_i[1:0]);
                        wdata_r <= cmd_wdata_i << {cmd_addr_i[1:0], 3'b000};
                        rdata_r <= {DATA_WIDTH{1'b0}};
                        err_r   <= misaligned_s;
                    end
                end
                RSP: begin
                    if (obi_rvalid_i) begin
                        rdata_r <= (we_r || obi_err_i) ? {DATA_WIDTH{1'b0}}
                                                       : extract_rdata(obi_rdata_i, size_r, addr_r[1:0]);
                        err_r   <= obi_err_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obi_manager_be.sv
// Self-checking bench for obi_manager_be: directed plan vectors plus randomized
// transactions checked against a byte-lane arithmetic model.
module tb_obi_manager_be;

    logic        clk_i;
    logic        reset_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [31:0] cmd_addr_i;
    logic [1:0]  cmd_size_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        obi_req_o;
    logic        obi_gnt_i;
    logic [31:0] obi_addr_o;
    logic        obi_we_o;
    logic [3:0]  obi_be_o;
    logic [31:0] obi_wdata_o;
    logic        obi_rvalid_i;
    logic        obi_rready_o;
    logic [31:0] obi_rdata_i;
    logic        obi_err_i;

    int checks;
    int errors;

    obi_manager_be #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i),
        .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o), .obi_be_o(obi_be_o),
        .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o),
        .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // One complete transaction with a scripted subordinate; expectations from byte arithmetic.
    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input int gnt_dly, input int rv_dly,
                           input logic [31:0] rdata, input logic err, input int bp);
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        mis;
        int          off;
        int          nb;
        int          s;
        s   = int'(size);
        off = int'(addr % 32'd4);
        nb  = 1 << s;
        mis = (s == 3) || (s == 1 && (off % 2) != 0) || (s == 2 && off != 0);
        e_be = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) e_be[i] = 1'b1;
        end
        e_wdata = 32'(64'(wdata) * (64'd1 << (8 * off)));
        if (mis || we || err) e_rdata = 32'h0;
        else e_rdata = 32'((64'(rdata) / (64'd1 << (8 * off))) % (64'd1 << (8 * nb)));
        e_err = mis ? 1'b1 : err;

        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_size_i = size; cmd_wdata_i = wdata;
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++; $display("FAIL %s accept: cmd_ready_o=%b expected 1", name, cmd_ready_o);
        end
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; cmd_addr_i = $urandom; cmd_wdata_i = $urandom; cmd_we_i = 1'($urandom);
        if (!mis) begin
            for (int k = 0; k <= gnt_dly; k++) begin
                checks++;
                if ({obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_rready_o, rsp_valid_o}
                    !== {1'b1, addr, we, e_be, e_wdata, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL %s req[%0d]: req=%b addr=%h we=%b be=%b wdata=%h rready=%b rvalid=%b expected 1 %h %b %b %h 0 0",
                             name, k, obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_rready_o,
                             rsp_valid_o, addr, we, e_be, e_wdata);
                end
                obi_gnt_i    = (k == gnt_dly);
                obi_rvalid_i = (k == gnt_dly) ? 1'b0 : 1'($urandom);
                obi_rdata_i  = $urandom;
                obi_err_i    = 1'($urandom);
                @(posedge clk_i); #1;
            end
            obi_gnt_i = 1'b0;
            for (int k = 0; k <= rv_dly; k++) begin
                checks++;
                if ({obi_req_o, obi_rready_o, rsp_valid_o} !== 3'b010) begin
                    errors++;
                    $display("FAIL %s rsp_wait[%0d]: req,rready,rsp_valid=%b expected 010",
                             name, k, {obi_req_o, obi_rready_o, rsp_valid_o});
                end
                obi_rvalid_i = (k == rv_dly);
                obi_rdata_i  = (k == rv_dly) ? rdata : $urandom;
                obi_err_i    = (k == rv_dly) ? err : 1'($urandom);
                @(posedge clk_i); #1;
            end
            obi_rvalid_i = 1'b0; obi_err_i = 1'b0; obi_rdata_i = $urandom;
        end
        for (int k = 0; k <= bp; k++) begin
            checks++;
            if ({rsp_valid_o, rsp_err_o, rsp_rdata_o, cmd_ready_o, obi_req_o}
                !== {1'b1, e_err, e_rdata, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s done[%0d]: valid=%b err=%b rdata=%h cmd_ready=%b req=%b expected 1 %b %h 0 0",
                         name, k, rsp_valid_o, rsp_err_o, rsp_rdata_o, cmd_ready_o, obi_req_o, e_err, e_rdata);
            end
            rsp_ready_i = (k == bp);
            obi_rvalid_i = 1'($urandom);
            @(posedge clk_i); #1;
        end
        rsp_ready_i = 1'b0; obi_rvalid_i = 1'b0;
        checks++;
        if ({rsp_valid_o, cmd_ready_o, obi_req_o} !== 3'b010) begin
            errors++;
            $display("FAIL %s release: rsp_valid,cmd_ready,req=%b expected 010",
                     name, {rsp_valid_o, cmd_ready_o, obi_req_o});
        end
    endtask

    task automatic test_reset();
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h4; cmd_size_i = 2'd2; cmd_wdata_i = 32'h1234_5678;
        reset_ni = 1'b0;
        #2;
        checks++;
        if ({obi_req_o, rsp_valid_o, cmd_ready_o, obi_rready_o, obi_we_o, obi_be_o, obi_addr_o,
             obi_wdata_o, rsp_rdata_o, rsp_err_o} !== {4'b0010, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: req=%b rsp_valid=%b cmd_ready=%b rready=%b we=%b be=%b addr=%h wdata=%h rdata=%h err=%b expected all 0 except cmd_ready=1",
                     obi_req_o, rsp_valid_o, cmd_ready_o, obi_rready_o, obi_we_o, obi_be_o, obi_addr_o,
                     obi_wdata_o, rsp_rdata_o, rsp_err_o);
        end
        #3 reset_ni = 1'b1;
        #1;
        checks++;
        if ({obi_req_o, rsp_valid_o, cmd_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release: req,rsp_valid,cmd_ready=%b expected 001",
                     {obi_req_o, rsp_valid_o, cmd_ready_o});
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_txn();
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h8; cmd_size_i = 2'd2;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        reset_ni = 1'b0;
        #2;
        checks++;
        if ({obi_req_o, obi_rready_o, rsp_valid_o, cmd_ready_o} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_in_req: req,rready,rsp_valid,cmd_ready=%b expected 0001",
                     {obi_req_o, obi_rready_o, rsp_valid_o, cmd_ready_o});
        end
        #2 reset_ni = 1'b1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_addr_i = 32'h1; cmd_size_i = 2'd1;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        reset_ni = 1'b0;
        #2;
        checks++;
        if ({rsp_valid_o, rsp_err_o, cmd_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL reset_in_done: rsp_valid,err,cmd_ready=%b expected 001",
                     {rsp_valid_o, rsp_err_o, cmd_ready_o});
        end
        #2 reset_ni = 1'b1;
    endtask

    task automatic test_word_read();
        run_txn("word_read", 1'b0, 32'h4, 2'd2, $urandom, 0, 0, 32'hDA7A5EAD, 1'b0, 0);
    endtask

    task automatic test_byte_write_delayed_grant();
        run_txn("byte_write", 1'b1, 32'h6, 2'd0, 32'h0000C0DE, 3, 0, $urandom, 1'b0, 0);
    endtask

    task automatic test_half_read();
        run_txn("half_read", 1'b0, 32'h2, 2'd1, $urandom, 0, 0, 32'h1337C0DE, 1'b0, 0);
    endtask

    task automatic test_misaligned_and_error();
        run_txn("misaligned_word", 1'b0, 32'h3, 2'd2, $urandom, 0, 0, $urandom, 1'b0, 0);
        run_txn("reserved_size", 1'b1, 32'h0, 2'd3, $urandom, 0, 0, $urandom, 1'b0, 0);
        run_txn("sub_error", 1'b0, 32'hFFFFFFFC, 2'd2, $urandom, 0, 1, 32'hFFFF_FFFF, 1'b1, 0);
        run_txn("write_error", 1'b1, 32'h10, 2'd1, $urandom, 1, 0, 32'hFFFF_FFFF, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        run_txn("backpressure", 1'b0, 32'h21, 2'd0, $urandom, 0, 2, 32'hA5B6C7D8, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            int          sz;
            sz = int'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) a[0] = 1'b0;
                if (sz == 2) a[1:0] = 2'b00;
            end
            run_txn("random", 1'($urandom), a, 2'(sz), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 32'h0; cmd_size_i = 2'd0;
        cmd_wdata_i = 32'h0; rsp_ready_i = 1'b0; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
        obi_rdata_i = 32'h0; obi_err_i = 1'b0;
        #12 reset_ni = 1'b1;
        test_reset();
        test_word_read();
        test_byte_write_delayed_grant();
        test_half_read();
        test_misaligned_and_error();
        test_backpressure();
        test_reset_mid_txn();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
